lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit controller in the MEM stage of the RV32I core.
- Takes is_load/is_store, funct3 and the ALU-computed address from the pipeline.
- Sequences a single outstanding request on the data-memory req/gnt/rvalid bus, with byte-lane alignment and load sign/zero extension.
- Stalls the pipeline for the duration of the access and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles spent in REQ+WAIT before bus error; must be ≥2.
- XLEN, 32: data/address width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- is_load_instr_i  in  1  MEM-stage instruction is a load.
- is_store_instr_i  in  1  MEM-stage instruction is a store.
- funct3_i  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  XLEN  effective byte address.
- store_data_i  in  XLEN  rs2 value.
- flush_i  in  1  kill the MEM-stage instruction.
- mem_req_o  out  1  request valid.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  XLEN  read word.
- stall_o  out  1  hold IF..MEM.
- load_valid_o  out  1  one-cycle pulse; load_data_o valid.
- load_data_o  out  XLEN  extended load result.
- addr_exc_o  out  1  misaligned address or invalid funct3 (combinational, IDLE only).
- bus_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst_ni=0 at a clock edge): state=IDLE, timeout counter=0, captured regs=0. All outputs read 0 during reset.
- States: IDLE, REQ, WAIT, DONE.
- "Access" = load or store. Misaligned = H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0. Invalid funct3 = 011, 110, 111, or loads/stores outside the legal set (store funct3 must be 000–010).
- IDLE:
  - Access, no flush, aligned/valid: stall_o=1 combinationally. Capture addr, we, be, wdata, funct3. Next state REQ; counter cleared.
  - Access with an exception: addr_exc_o=1, stall_o=0, no request, stay IDLE.
  - flush_i=1: nothing happens.
- REQ:
  - mem_req_o=1; addr/we/be/wdata held stable until grant. stall_o=1.
  - mem_gnt_i: store → DONE; load → WAIT.
  - flush_i before grant (flush and gnt in the same cycle counts as granted): drop req next cycle, go IDLE, stall_o=0 in that cycle.
- WAIT:
  - stall_o=1. On mem_rvalid_i, capture the extended data → DONE.
  - flush_i here is latched into a kill flag; the response is still consumed.
  - rvalid in the same cycle as grant is illegal (bus guarantees ≥1-cycle latency).
- DONE:
  - stall_o=0 for exactly one cycle, so the pipeline advances at this edge.
  - load_valid_o=1 only for an unkilled load.
  - Next state IDLE. The same instruction can never retrigger.
- Timeout: counter increments each cycle in REQ/WAIT. Reaching TIMEOUT_CYCLES-1 → DONE with bus_err_o=1, load_valid_o=0; a pending request is dropped.
- Store lanes (k = addr[1:0]):
  - SB: be=4'b0001<<k, wdata={4{sd[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{sd[15:0]}}.
  - SW: be=4'b1111, wdata=sd.
- Loads: be=4'b1111. Result is rdata>>(8·k), then sign-extend (B/H) or zero-extend (BU/HU); W is passed through unchanged.
- load_data_o holds its last value outside load_valid_o.
- Reset asserted mid-access returns to IDLE immediately; any outstanding response is ignored.

Decomposition:
- Shared package/header (alongside the existing encodings header): LSU state encodings; funct3 width codes (LB..LHU, SB..SW); be patterns.
- One natural sub-module: lsu_align. Purely combinational store lane/be generation and load extract/extend. Keeps the FSM file free of datapath.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt after 2 cycles → req held 2 cycles with mem_addr 0x100, be=1111; stall released in DONE; no load_valid.
- LB addr=0x203, rdata=0x80FF_0000 → be=1111; load_data_o=0xFFFFFF80, load_valid 1 cycle. LBU same → 0x00000080.
- SH addr=0x102, data=0x0000ABCD → be=1100, wdata=0xABCDABCD. LW addr=0x102 → addr_exc_o=1, no mem_req_o, stall_o=0.
- Load, flush in REQ before gnt → mem_req_o drops next cycle, IDLE. Load, flush in WAIT, rvalid later → no load_valid_o.
- Never grant, TIMEOUT_CYCLES=16 → bus_err_o pulse once after 15 cycles in REQ, then IDLE.
- rst_ni low while in WAIT → IDLE next edge, outputs 0; late rvalid ignored.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared definitions for the load/store unit controller.
//   - LSU FSM state encoding
//   - funct3 access-width codes for loads and stores
//   - byte-enable patterns
//   - legality / alignment helpers used when an access is accepted in IDLE
package lsu_ctrl_pkg;

  localparam int LSU_XLEN  = 32;
  localparam int LSU_LANES = LSU_XLEN / 8;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Load width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte-enable patterns
  localparam logic [LSU_LANES-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [LSU_LANES-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [LSU_LANES-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [LSU_LANES-1:0] BE_WORD    = 4'b1111;

  // funct3 is legal for the given access direction.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  // funct3[1:0] encodes the width for both signed and unsigned loads.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane datapath for the LSU.
//   Store side: from funct3, address offset and rs2 produce byte enables and
//               lane-replicated write data (loads always use all four lanes).
//   Load side:  from the captured funct3/offset and the returned word produce
//               the shifted and sign/zero-extended load result.
// Ports:
//   is_store_i, st_funct3_i, st_off_i, st_data_i -> st_be_o, st_wdata_o
//   ld_funct3_i, ld_off_i, ld_rdata_i            -> ld_data_o
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_store_i,
  input  logic [2:0]        st_funct3_i,
  input  logic [1:0]        st_off_i,
  input  logic [XLEN-1:0]   st_data_i,
  output logic [XLEN/8-1:0] st_be_o,
  output logic [XLEN-1:0]   st_wdata_o,
  input  logic [2:0]        ld_funct3_i,
  input  logic [1:0]        ld_off_i,
  input  logic [XLEN-1:0]   ld_rdata_i,
  output logic [XLEN-1:0]   ld_data_o
);

  logic [XLEN-1:0] ld_shifted;

  // Store lanes: the memory picks the lane via be, so the data is simply
  // replicated across every lane it could land in.
  always_comb begin
    st_be_o    = BE_WORD;
    st_wdata_o = st_data_i;
    if (is_store_i) begin
      case (st_funct3_i)
        F3_SB: begin
          st_be_o    = BE_BYTE0 << st_off_i;
          st_wdata_o = {4{st_data_i[7:0]}};
        end
        F3_SH: begin
          st_be_o    = st_off_i[1] ? BE_HALF_HI : BE_HALF_LO;
          st_wdata_o = {2{st_data_i[15:0]}};
        end
        default: begin
          st_be_o    = BE_WORD;
          st_wdata_o = st_data_i;
        end
      endcase
    end
  end

  assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      F3_LH:   ld_data_o = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LBU:  ld_data_o = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      F3_LHU:  ld_data_o = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store controller for the RV32I core.
//   Accepts one load/store from the pipeline, runs a single outstanding
//   req/gnt/rvalid transaction, stalls the pipeline while it is in flight,
//   and reports misaligned/invalid accesses and bus timeouts.
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   is_load_instr_i, is_store_instr_i  MEM-stage instruction kind
//   funct3_i, addr_i, store_data_i     access width/sign, byte address, rs2
//   flush_i                            kill the MEM-stage instruction
//   mem_req_o/we/addr/be/wdata         request channel (held until grant)
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  grant and read-response channel
//   stall_o                            hold IF..MEM
//   load_valid_o, load_data_o          one-cycle load result pulse
//   addr_exc_o                         misaligned/invalid (IDLE, combinational)
//   bus_err_o                          one-cycle timeout pulse
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN           = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            is_load_instr_i,
  input  logic            is_store_instr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_o,
  output logic            load_valid_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            addr_exc_o,
  output logic            bus_err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  // Last REQ/WAIT cycle before the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  load_data_q, load_data_d;
  logic [3:0]       be_q, be_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic             we_q, we_d;
  logic             kill_q, kill_d;
  logic             load_valid_q, load_valid_d;
  logic             bus_err_q, bus_err_d;

  logic            is_ld, is_st, access, exc, timeout;
  logic            stall, addr_exc;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_ldata;

  // A load wins if both kind bits are ever raised together.
  assign is_ld   = is_load_instr_i;
  assign is_st   = is_store_instr_i & ~is_load_instr_i;
  assign access  = (is_ld | is_st) & ~flush_i;
  assign exc     = ~f3_legal(is_st, funct3_i) | f3_misaligned(funct3_i, addr_i[1:0]);
  assign timeout = (cnt_q >= CNT_LAST);

  lsu_align #(.XLEN(XLEN)) u_align (
    .is_store_i  (is_st),
    .st_funct3_i (funct3_i),
    .st_off_i    (addr_i[1:0]),
    .st_data_i   (store_data_i),
    .st_be_o     (al_be),
    .st_wdata_o  (al_wdata),
    .ld_funct3_i (funct3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (mem_rdata_i),
    .ld_data_o   (al_ldata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    kill_d       = kill_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    stall        = 1'b0;
    addr_exc     = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        cnt_d  = '0;
        kill_d = 1'b0;
        if (access) begin
          if (exc) begin
            addr_exc = 1'b1;
          end else begin
            stall    = 1'b1;
            addr_d   = {addr_i[XLEN-1:2], 2'b00};
            off_d    = addr_i[1:0];
            we_d     = is_st;
            be_d     = al_be;
            wdata_d  = al_wdata;
            funct3_d = funct3_i;
            state_d  = LSU_REQ;
          end
        end
      end

      LSU_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_gnt_i) begin
          // A flush coinciding with the grant still completes the bus
          // transaction; only the load result is suppressed.
          kill_d  = flush_i;
          state_d = we_q ? LSU_DONE : LSU_WAIT;
        end else if (flush_i) begin
          stall   = 1'b0;
          state_d = LSU_IDLE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = LSU_DONE;
        end
      end

      LSU_WAIT: begin
        stall  = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        kill_d = kill_q | flush_i;
        if (mem_rvalid_i) begin
          state_d = LSU_DONE;
          if (!kill_d) begin
            load_valid_d = 1'b1;
            load_data_d  = al_ldata;
          end
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = LSU_DONE;
        end
      end

      LSU_DONE: begin
        // Stall released for this one cycle so the pipeline advances.
        state_d = LSU_IDLE;
      end

      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      kill_q       <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      kill_q       <= kill_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Every output is forced low while reset is held, including the cycles
  // before the reset edge has been sampled.
  assign mem_req_o    = rst_ni & (state_q == LSU_REQ);
  assign mem_we_o     = rst_ni & we_q;
  assign mem_addr_o   = rst_ni ? addr_q  : '0;
  assign mem_be_o     = rst_ni ? be_q    : '0;
  assign mem_wdata_o  = rst_ni ? wdata_q : '0;
  assign stall_o      = rst_ni & stall;
  assign addr_exc_o   = rst_ni & addr_exc;
  assign load_valid_o = rst_ni & load_valid_q;
  assign load_data_o  = rst_ni ? load_data_q : '0;
  assign bus_err_o    = rst_ni & bus_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed + randomized bench for lsu_ctrl with a behavioural
// reference for legality, byte enables, store data and load extension.
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        is_load_instr_i, is_store_instr_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        stall_o, load_valid_o, addr_exc_o, bus_err_o;
  logic [31:0] load_data_o;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_ld = '0;

  always #5 clk_i = ~clk_i;

  lsu_ctrl #(.TIMEOUT_CYCLES(16), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .is_load_instr_i(is_load_instr_i), .is_store_instr_i(is_store_instr_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .addr_exc_o(addr_exc_o), .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    is_load_instr_i  = 1'b0;
    is_store_instr_i = 1'b0;
    funct3_i         = 3'b000;
    addr_i           = '0;
    store_data_i     = '0;
    flush_i          = 1'b0;
    mem_gnt_i        = 1'b0;
    mem_rvalid_i     = 1'b0;
    mem_rdata_i      = '0;
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ref_exc(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (ld) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else    legal = f3 inside {3'd0, 3'd1, 3'd2};
    return !legal || ((a % acc_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] ref_be(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int k;
    k = int'(a % 4);
    if (ld) return 32'd15;
    case (f3)
      3'd0:    return 32'd1 << k;
      3'd1:    return (k >= 2) ? 32'd12 : 32'd3;
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      3'd0:    return (sd % 256) * 32'h0101_0101;
      3'd1:    return (sd % 65536) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    longint v;
    int     k;
    k = int'(a % 4);
    v = longint'(w) >> (8 * k);
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  // One complete access from IDLE back to IDLE; called at posedge+1.
  task automatic run_txn(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int gdly, input int rdly,
                         input logic [31:0] rd);
    bit          exc;
    logic [31:0] be_e;
    exc  = ref_exc(ld, f3, a);
    be_e = ref_be(ld, f3, a);
    is_load_instr_i  = ld;
    is_store_instr_i = !ld;
    funct3_i         = f3;
    addr_i           = a;
    store_data_i     = sd;
    #1;
    chk1("idle_exc", addr_exc_o, exc);
    chk1("idle_stall", stall_o, !exc);
    tick();
    if (exc) begin
      chk1("exc_noreq", mem_req_o, 1'b0);
      set_idle();
      return;
    end
    for (int c = 0; c <= gdly; c++) begin
      mem_gnt_i = (c == gdly);
      #1;
      chk1("req_valid", mem_req_o, 1'b1);
      chk1("req_stall", stall_o, 1'b1);
      chk("req_addr", mem_addr_o, a & 32'hFFFF_FFFC);
      chk("req_be", 32'(mem_be_o), be_e);
      chk1("req_we", mem_we_o, !ld);
      if (!ld) chk("req_wdata", mem_wdata_o, ref_wdata(f3, sd));
      tick();
      mem_gnt_i = 1'b0;
    end
    if (ld) begin
      for (int c = 0; c <= rdly; c++) begin
        mem_rvalid_i = (c == rdly);
        mem_rdata_i  = (c == rdly) ? rd : $urandom;
        #1;
        chk1("wait_stall", stall_o, 1'b1);
        chk1("wait_noreq", mem_req_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
      end
      exp_ld = ref_load(f3, a, rd);
    end
    set_idle();
    #1;
    chk1("done_stall", stall_o, 1'b0);
    chk1("done_lvalid", load_valid_o, ld);
    chk1("done_berr", bus_err_o, 1'b0);
    chk("done_ldata", load_data_o, exp_ld);
    tick();
    chk1("post_lvalid", load_valid_o, 1'b0);
    chk("post_ldata_hold", load_data_o, exp_ld);
  endtask

  initial begin
    // ---- reset state ----
    set_idle();
    rst_ni = 1'b0;
    is_load_instr_i = 1'b1;
    tick();
    tick();
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_req", mem_req_o, 1'b0);
    chk1("rst_exc", addr_exc_o, 1'b0);
    chk1("rst_lvalid", load_valid_o, 1'b0);
    chk1("rst_berr", bus_err_o, 1'b0);
    chk("rst_ldata", load_data_o, 32'h0);
    chk("rst_be", 32'(mem_be_o), 32'h0);
    rst_ni = 1'b1;
    set_idle();
    tick();

    // ---- directed cases ----
    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 0, 32'h0);   // SW, gnt on 2nd cycle
    run_txn(1'b1, 3'b000, 32'h0000_0203, 32'h0, 0, 1, 32'h80FF_0000);   // LB -> FFFFFF80
    chk("lb_result", exp_ld, 32'hFFFF_FF80);
    run_txn(1'b1, 3'b100, 32'h0000_0203, 32'h0, 2, 0, 32'h80FF_0000);   // LBU -> 00000080
    chk("lbu_result", load_data_o, 32'h0000_0080);
    run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 0, 0, 32'h0);   // SH upper half
    run_txn(1'b1, 3'b010, 32'h0000_0102, 32'h0, 0, 0, 32'h0);           // LW misaligned
    run_txn(1'b0, 3'b100, 32'h0000_0100, 32'h1, 0, 0, 32'h0);           // store funct3 illegal
    run_txn(1'b1, 3'b101, 32'h0000_0002, 32'h0, 0, 2, 32'h9876_5432);   // LHU upper half

    // flush in IDLE: nothing happens, even for an illegal access
    is_store_instr_i = 1'b1; funct3_i = 3'b111; flush_i = 1'b1;
    #1;
    chk1("flush_idle_exc", addr_exc_o, 1'b0);
    chk1("flush_idle_stall", stall_o, 1'b0);
    tick();
    chk1("flush_idle_noreq", mem_req_o, 1'b0);
    set_idle();

    // flush in REQ before grant
    is_load_instr_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h300;
    tick();
    flush_i = 1'b1;
    #1;
    chk1("flreq_req", mem_req_o, 1'b1);
    chk1("flreq_stall", stall_o, 1'b0);
    tick();
    set_idle();
    #1;
    chk1("flreq_dropped", mem_req_o, 1'b0);
    chk1("flreq_nostall", stall_o, 1'b0);
    tick();

    // flush in WAIT, response arrives later and is consumed silently
    is_load_instr_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h400;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; flush_i = 1'b1;
    #1;
    chk1("flwait_stall", stall_o, 1'b1);
    tick();
    flush_i = 1'b0;
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    tick();
    set_idle();
    #1;
    chk1("flwait_nolv", load_valid_o, 1'b0);
    chk1("flwait_stall_done", stall_o, 1'b0);
    chk("flwait_ldata_hold", load_data_o, exp_ld);
    tick();

    // timeout: never grant
    is_load_instr_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h500;
    tick();
    for (int c = 0; c < 15; c++) begin
      chk1("to_req", mem_req_o, 1'b1);
      chk1("to_noerr", bus_err_o, 1'b0);
      tick();
    end
    set_idle();
    #1;
    chk1("to_berr", bus_err_o, 1'b1);
    chk1("to_req_dropped", mem_req_o, 1'b0);
    chk1("to_nolv", load_valid_o, 1'b0);
    chk1("to_stall", stall_o, 1'b0);
    tick();
    chk1("to_berr_pulse", bus_err_o, 1'b0);
    chk1("to_idle_noreq", mem_req_o, 1'b0);

    // reset asserted while in WAIT; late response ignored
    is_load_instr_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h602;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk1("rstw_stall", stall_o, 1'b0);
    chk1("rstw_req", mem_req_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    set_idle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    chk1("rstw_nolv0", load_valid_o, 1'b0);
    chk1("rstw_nostall", stall_o, 1'b0);
    tick();
    mem_rvalid_i = 1'b0;
    chk1("rstw_nolv1", load_valid_o, 1'b0);
    chk1("rstw_noreq", mem_req_o, 1'b0);
    chk("rstw_ldata", load_data_o, 32'h0);
    exp_ld = '0;

    // ---- randomized accesses ----
    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'($urandom), 32'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), 32'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
